// File: rtl/pulse_gen_if.sv
// pulse_gen_if: trigger/width/gap controls and pulse-train status for pulse_gen.
interface pulse_gen_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
);
  logic              trig_i;
  logic [CNT_W-1:0]  width_i;
  logic [CNT_W-1:0]  gap_i;
  logic              sig_o;
  logic              busy_o;
  logic [PEND_W-1:0] pend_o;
  logic              ovf_o;
  modport master (output trig_i, width_i, gap_i, input sig_o, busy_o, pend_o, ovf_o);
  modport slave  (input trig_i, width_i, gap_i, output sig_o, busy_o, pend_o, ovf_o);
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: trigger-to-pulse generator with programmable width/gap and a saturating trigger queue.
module pulse_gen #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input logic       clk,
  input logic       rst,
  pulse_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [PEND_W-1:0] PMAX = '1;
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, g, g_n, w_eff, g_eff;
  logic [PEND_W-1:0] pend, pend_n;
  logic              sig, sig_n, ovf, ovf_n, start, fin;
  always_comb begin
    w_eff   = (bus.width_i == '0) ? CNT_W'(1) : bus.width_i;
    g_eff   = (bus.gap_i == '0) ? CNT_W'(1) : bus.gap_i;
    fin     = (cnt == '0);
    start   = (pend != '0 || bus.trig_i) && (state == IDLE || (state == LOW && fin));
    state_n = start ? HIGH : (state == HIGH && fin) ? LOW : (state == LOW && fin) ? IDLE : state;
    cnt_n   = start ? w_eff - CNT_W'(1) : (state == HIGH && fin) ? g - CNT_W'(1) : fin ? cnt : cnt - CNT_W'(1);
    g_n     = start ? g_eff : g;
    sig_n   = start || (state == HIGH && !fin);
    // A trigger is consumed only by a start with an empty queue; otherwise it queues or drops.
    ovf_n   = bus.trig_i && !start && pend == PMAX;
    pend_n  = (start && pend != '0 && !bus.trig_i) ? pend - PEND_W'(1) :
              (bus.trig_i && !start && pend != PMAX) ? pend + PEND_W'(1) : pend;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      g     <= '0;
      pend  <= '0;
      sig   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      g     <= g_n;
      pend  <= pend_n;
      sig   <= sig_n;
      ovf   <= ovf_n;
    end
  end
  assign bus.sig_o  = sig;
  assign bus.busy_o = (state != IDLE);
  assign bus.pend_o = pend;
  assign bus.ovf_o  = ovf;
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed checks of pulse_gen timing, queuing, saturation and reset.
module tb_pulse_gen;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  pulse_gen_if #(.CNT_W(8), .PEND_W(2)) bus ();
  pulse_gen #(.CNT_W(8), .PEND_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int es[10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    int ep[10] = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
    int sp[7]  = '{0, 1, 2, 3, 3, 3, 3};
    int so[7]  = '{0, 0, 0, 0, 1, 1, 0};
    int rises, ovfs;
    logic prev;
    rst = 1'b1;
    bus.trig_i = 1'b0;
    bus.width_i = '0;
    bus.gap_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_sig", 32'(bus.sig_o), 0);
    chk("reset_busy", 32'(bus.busy_o), 0);
    chk("reset_pend", 32'(bus.pend_o), 0);
    chk("reset_ovf", 32'(bus.ovf_o), 0);
    // single trigger, width 3, gap 2
    bus.width_i = 8'd3;
    bus.gap_i = 8'd2;
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i = 1'b0;
    chk("single_rise", 32'(bus.sig_o), 1);
    chk("single_busy", 32'(bus.busy_o), 1);
    tick(); chk("single_h1", 32'(bus.sig_o), 1);
    tick(); chk("single_h2", 32'(bus.sig_o), 1);
    tick(); chk("single_fall", 32'(bus.sig_o), 0);
    chk("single_pend", 32'(bus.pend_o), 0);
    tick(); chk("single_gap_busy", 32'(bus.busy_o), 1);
    tick(); chk("single_idle", 32'(bus.busy_o), 0);
    chk("single_idle_sig", 32'(bus.sig_o), 0);
    // three consecutive triggers, width 2, gap 1
    bus.width_i = 8'd2;
    bus.gap_i = 8'd1;
    for (int i = 0; i < 10; i++) begin
      bus.trig_i = (i < 3);
      tick();
      chk($sformatf("burst_sig%0d", i), 32'(bus.sig_o), 32'(es[i]));
      chk($sformatf("burst_pend%0d", i), 32'(bus.pend_o), 32'(ep[i]));
    end
    bus.trig_i = 1'b0;
    chk("burst_idle", 32'(bus.busy_o), 0);
    // zero width/gap act as 1, alternate triggers
    bus.width_i = 8'd0;
    bus.gap_i = 8'd0;
    for (int i = 0; i < 6; i++) begin
      bus.trig_i = (i % 2 == 0);
      tick();
      chk($sformatf("zero_sig%0d", i), 32'(bus.sig_o), 32'(i % 2 == 0));
      chk($sformatf("zero_pend%0d", i), 32'(bus.pend_o), 0);
    end
    bus.trig_i = 1'b0;
    tick();
    chk("zero_idle", 32'(bus.busy_o), 0);
    // saturation: six triggers during a long pulse with a 2-bit queue
    bus.width_i = 8'd10;
    bus.gap_i = 8'd1;
    rises = 0;
    ovfs = 0;
    prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.trig_i = (i < 6);
      tick();
      if (bus.sig_o && !prev) rises++;
      prev = bus.sig_o;
      ovfs += int'(bus.ovf_o);
      if (i < 7) begin
        chk($sformatf("sat_pend%0d", i), 32'(bus.pend_o), 32'(sp[i]));
        chk($sformatf("sat_ovf%0d", i), 32'(bus.ovf_o), 32'(so[i]));
      end
    end
    bus.trig_i = 1'b0;
    chk("sat_rises", 32'(rises), 4);
    chk("sat_ovf_count", 32'(ovfs), 2);
    chk("sat_idle", 32'(bus.busy_o), 0);
    chk("sat_pend_end", 32'(bus.pend_o), 0);
    // reset during a 5-cycle pulse with two queued
    bus.width_i = 8'd5;
    bus.gap_i = 8'd1;
    bus.trig_i = 1'b1;
    repeat (3) tick();
    chk("rst_pre_pend", 32'(bus.pend_o), 2);
    chk("rst_pre_sig", 32'(bus.sig_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.trig_i = 1'b0;
    chk("rst_sig", 32'(bus.sig_o), 0);
    chk("rst_pend", 32'(bus.pend_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_ovf", 32'(bus.ovf_o), 0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rises += int'(bus.sig_o);
    end
    chk("rst_no_pulses", 32'(rises), 0);
    // trigger in the final LOW cycle restarts with no idle bubble
    bus.width_i = 8'd2;
    bus.gap_i = 8'd3;
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i = 1'b0;
    chk("last_low_rise0", 32'(bus.sig_o), 1);
    tick(); chk("last_low_h", 32'(bus.sig_o), 1);
    tick(); chk("last_low_l0", 32'(bus.sig_o), 0);
    tick(); chk("last_low_l1", 32'(bus.busy_o), 1);
    tick(); chk("last_low_l2", 32'(bus.sig_o), 0);
    chk("last_low_l2_busy", 32'(bus.busy_o), 1);
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i = 1'b0;
    chk("last_low_restart", 32'(bus.sig_o), 1);
    chk("last_low_busy", 32'(bus.busy_o), 1);
    chk("last_low_pend", 32'(bus.pend_o), 0);
    repeat (6) tick();
    chk("last_low_idle", 32'(bus.busy_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
